// File: rtl/conv_layer_sequencer.sv
// Per-layer control sequencer for one conv tile: weight-converter reset, bias load,
// pixel streaming and result write-back counting. Optional macro: CONV_SEQ_PERF_CNT_EN.
module conv_layer_sequencer #(
  parameter int FM_AW    = 13,
  parameter int WM_AW    = 8,
  parameter int BM_AW    = 9,
  parameter int BUF_W    = 9,
  parameter int WCVT_CYC = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic             abort,
  input  logic             cfg_pw_mode,
  input  logic [3:0]       cfg_scale,
  input  logic [BUF_W-1:0] cfg_row_len,
  input  logic [FM_AW-1:0] cfg_pix_num,
  input  logic [WM_AW-1:0] cfg_groups,
  input  logic [FM_AW-1:0] cfg_fm_rd_base,
  input  logic [FM_AW-1:0] cfg_fm_wr_base,
  input  logic             stall,
  input  logic             conv_valid_out,
  output logic             conv_data_valid_in,
  output logic             adder_rst,
  output logic [3:0]       conv_scale,
  output logic             pw_mode,
  output logic [BUF_W-1:0] buff_len_ctrl,
  output logic             buff_len_rst,
  output logic [FM_AW-1:0] fm_rd_addr,
  output logic [FM_AW-1:0] fm_wr_addr,
  output logic [WM_AW-1:0] wm_addr_rd,
  output logic             wm_cvt_rstn,
  output logic [BM_AW-1:0] bm_addr_rd,
  output logic             bias_out_valid,
  output logic [2:0]       current_state,
  output logic             busy,
`ifdef CONV_SEQ_PERF_CNT_EN
  output logic [31:0]      perf_cycles,
`endif
  output logic             done
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_WCVT   = 3'd1;
  localparam logic [2:0] S_BIAS   = 3'd2;
  localparam logic [2:0] S_STREAM = 3'd3;
  localparam logic [2:0] S_DRAIN  = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  localparam int WCW = (WCVT_CYC < 1) ? 1 : $clog2(WCVT_CYC + 1);

  logic [2:0]       r_state;
  logic             r_cfg_pw;
  logic [3:0]       r_cfg_scale;
  logic [BUF_W-1:0] r_cfg_row_len;
  logic [FM_AW-1:0] r_cfg_pix;
  logic [WM_AW-1:0] r_cfg_groups;
  logic [FM_AW-1:0] r_cfg_rd_base;

  logic [FM_AW-1:0] r_pix_cnt;
  logic [FM_AW-1:0] r_out_cnt;
  logic [WM_AW-1:0] r_group;
  logic [WCW-1:0]   r_wait;

  logic             r_valid;
  logic             r_adder_rst;
  logic             r_buf_rst;
  logic             r_bias_v;
  logic             r_cvt_rstn;
  logic             r_done;
  logic [FM_AW-1:0] r_rd_addr;
  logic [FM_AW-1:0] r_wr_addr;
  logic [WM_AW-1:0] r_wm_addr;
  logic [BM_AW-1:0] r_bm_addr;

  logic             w_start_ok;
  logic [FM_AW-1:0] w_pix_issued;
  logic             w_pix_last;
  logic             w_out_full;
  logic             w_count_out;
  logic [WM_AW:0]   w_group_ext;
  logic             w_more_groups;
  logic             w_wcvt_end;
  logic             w_enter_bias;
  logic [WM_AW-1:0] w_bias_group;

  assign w_start_ok    = start && (r_state == S_IDLE);
  assign w_pix_issued  = r_pix_cnt + FM_AW'(r_valid);
  assign w_pix_last    = (w_pix_issued == r_cfg_pix);
  assign w_out_full    = (r_out_cnt == r_cfg_pix);
  // Results past the group's pixel count are dropped so fm_wr_addr stays aligned.
  assign w_count_out   = conv_valid_out && !w_out_full &&
                         ((r_state == S_STREAM) || (r_state == S_DRAIN));
  assign w_group_ext   = {1'b0, r_group} + (WM_AW + 1)'(1);
  assign w_more_groups = (w_group_ext < {1'b0, r_cfg_groups});
  assign w_wcvt_end    = (r_state == S_WCVT) && (r_wait == WCW'(WCVT_CYC));
  assign w_enter_bias  = w_wcvt_end ||
                         ((r_state == S_DRAIN) && w_out_full && w_more_groups);
  assign w_bias_group  = (r_state == S_DRAIN) ? w_group_ext[WM_AW-1:0] : r_group;

  // NOTE: latched config survives abort and is cleared only by rstn, so it lives in its own block.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cfg_pw      <= 1'b0;
      r_cfg_scale   <= '0;
      r_cfg_row_len <= '0;
      r_cfg_pix     <= '0;
      r_cfg_groups  <= '0;
      r_cfg_rd_base <= '0;
    end else if (w_start_ok && !abort) begin
      r_cfg_pw      <= cfg_pw_mode;
      r_cfg_scale   <= cfg_scale;
      r_cfg_row_len <= cfg_row_len;
      r_cfg_pix     <= cfg_pix_num;
      r_cfg_groups  <= cfg_groups;
      r_cfg_rd_base <= cfg_fm_rd_base;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn || abort) begin
      r_state     <= S_IDLE;
      r_pix_cnt   <= '0;
      r_out_cnt   <= '0;
      r_group     <= '0;
      r_wait      <= '0;
      r_valid     <= 1'b0;
      r_adder_rst <= 1'b0;
      r_buf_rst   <= 1'b0;
      r_bias_v    <= 1'b0;
      r_cvt_rstn  <= 1'b1;
      r_done      <= 1'b0;
      r_rd_addr   <= '0;
      r_wr_addr   <= '0;
      r_wm_addr   <= '0;
      r_bm_addr   <= '0;
    end else begin
      // NOTE: every state bit uses <=, so later assignments in this block override earlier defaults.
      r_adder_rst <= 1'b0;
      r_buf_rst   <= 1'b0;
      r_bias_v    <= 1'b0;
      r_cvt_rstn  <= 1'b1;
      r_done      <= 1'b0;

      if (w_count_out) begin
        r_out_cnt <= r_out_cnt + FM_AW'(1);
        r_wr_addr <= r_wr_addr + FM_AW'(1);
      end

      case (r_state)
        S_IDLE: if (start) begin
          r_rd_addr <= cfg_fm_rd_base;
          r_wr_addr <= cfg_fm_wr_base;
          r_group   <= '0;
          if ((cfg_pix_num == '0) || (cfg_groups == '0)) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end else begin
            r_state    <= S_WCVT;
            r_wait     <= '0;
            r_cvt_rstn <= 1'b0;
            r_buf_rst  <= 1'b1;
          end
        end
        S_WCVT: if (!w_wcvt_end) r_wait <= r_wait + WCW'(1);
        S_BIAS: begin
          r_state <= S_STREAM;
          r_valid <= !stall;
        end
        S_STREAM: begin
          if (r_valid) r_rd_addr <= r_rd_addr + FM_AW'(1);
          r_pix_cnt <= w_pix_issued;
          if (w_pix_last) begin
            r_valid <= 1'b0;
            r_state <= S_DRAIN;
          end else begin
            r_valid <= !stall;
          end
        end
        S_DRAIN: if (w_out_full && !w_more_groups) begin
          r_state <= S_DONE;
          r_done  <= 1'b1;
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase

      if (w_enter_bias) begin
        r_state     <= S_BIAS;
        r_group     <= w_bias_group;
        r_wm_addr   <= w_bias_group;
        r_bm_addr   <= BM_AW'(w_bias_group);
        r_bias_v    <= 1'b1;
        r_adder_rst <= 1'b1;
        r_pix_cnt   <= '0;
        r_out_cnt   <= '0;
        r_rd_addr   <= r_cfg_rd_base;
      end
    end
  end

`ifdef CONV_SEQ_PERF_CNT_EN
  logic [31:0] r_perf;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn || abort) begin
      r_perf <= '0;
    end else if (r_state == S_IDLE) begin
      if (start) r_perf <= '0;
    end else begin
      r_perf <= r_perf + 32'd1;
    end
  end

  assign perf_cycles = r_perf;
`endif

  assign conv_data_valid_in = r_valid;
  assign adder_rst          = r_adder_rst;
  assign conv_scale         = r_cfg_scale;
  assign pw_mode            = r_cfg_pw;
  assign buff_len_ctrl      = r_cfg_row_len;
  assign buff_len_rst       = r_buf_rst;
  assign fm_rd_addr         = r_rd_addr;
  assign fm_wr_addr         = r_wr_addr;
  assign wm_addr_rd         = r_wm_addr;
  assign wm_cvt_rstn        = r_cvt_rstn;
  assign bm_addr_rd         = r_bm_addr;
  assign bias_out_valid     = r_bias_v;
  assign current_state      = r_state;
  assign busy               = (r_state != S_IDLE);
  assign done               = r_done;

endmodule

// File: tb/tb_conv_layer_sequencer.sv
// Directed bench for conv_layer_sequencer with a 3-cycle datapath return model.
// Define CONV_SEQ_PERF_CNT_EN to also exercise the cycle counter.
module tb_conv_layer_sequencer;

  localparam int FM_AW = 13;
  localparam int WM_AW = 8;
  localparam int BM_AW = 9;
  localparam int BUF_W = 9;

  logic             clk = 1'b0;
  logic             rstn;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic             cfg_pw_mode = 1'b0;
  logic [3:0]       cfg_scale = '0;
  logic [BUF_W-1:0] cfg_row_len = '0;
  logic [FM_AW-1:0] cfg_pix_num = '0;
  logic [WM_AW-1:0] cfg_groups = '0;
  logic [FM_AW-1:0] cfg_fm_rd_base = '0;
  logic [FM_AW-1:0] cfg_fm_wr_base = '0;
  logic             stall = 1'b0;
  logic             conv_valid_out;

  logic             conv_data_valid_in, adder_rst, pw_mode, buff_len_rst;
  logic             wm_cvt_rstn, bias_out_valid, busy, done;
  logic [3:0]       conv_scale;
  logic [BUF_W-1:0] buff_len_ctrl;
  logic [FM_AW-1:0] fm_rd_addr, fm_wr_addr;
  logic [WM_AW-1:0] wm_addr_rd;
  logic [BM_AW-1:0] bm_addr_rd;
  logic [2:0]       current_state;
`ifdef CONV_SEQ_PERF_CNT_EN
  logic [31:0]      perf_cycles;
`endif

  conv_layer_sequencer dut (
    .clk(clk), .rstn(rstn), .start(start), .abort(abort),
    .cfg_pw_mode(cfg_pw_mode), .cfg_scale(cfg_scale), .cfg_row_len(cfg_row_len),
    .cfg_pix_num(cfg_pix_num), .cfg_groups(cfg_groups),
    .cfg_fm_rd_base(cfg_fm_rd_base), .cfg_fm_wr_base(cfg_fm_wr_base),
    .stall(stall), .conv_valid_out(conv_valid_out),
    .conv_data_valid_in(conv_data_valid_in), .adder_rst(adder_rst),
    .conv_scale(conv_scale), .pw_mode(pw_mode), .buff_len_ctrl(buff_len_ctrl),
    .buff_len_rst(buff_len_rst), .fm_rd_addr(fm_rd_addr), .fm_wr_addr(fm_wr_addr),
    .wm_addr_rd(wm_addr_rd), .wm_cvt_rstn(wm_cvt_rstn), .bm_addr_rd(bm_addr_rd),
    .bias_out_valid(bias_out_valid), .current_state(current_state), .busy(busy),
`ifdef CONV_SEQ_PERF_CNT_EN
    .perf_cycles(perf_cycles),
`endif
    .done(done)
  );

  always #5 clk = ~clk;

  // Datapath model: each valid_in comes back 3 cycles later; dup_mode echoes one extra cycle.
  logic [3:0] pipe;
  logic       dup_mode = 1'b0;
  always @(posedge clk or negedge rstn) begin
    if (!rstn) pipe <= '0;
    else       pipe <= {pipe[2:0], conv_data_valid_in};
  end
  assign conv_valid_out = pipe[2] | (dup_mode & pipe[3]);

  // Stall generator: once armed, 5 stall cycles start at the first issued pixel.
  logic stall_arm = 1'b0;
  bit   stall_fired = 1'b0;
  int   stall_left = 0;
  always @(negedge clk) begin
    if (!stall_arm) stall_fired = 1'b0;
    else if (conv_data_valid_in && !stall_fired) begin
      stall_fired = 1'b1;
      stall_left  = 5;
    end
    stall = (stall_left > 0);
    if (stall_left > 0) stall_left--;
  end

  logic stall_q;
  always @(posedge clk) stall_q <= stall;

  typedef struct {
    int vin, bias, adder, dn, bsy, cvt, brst, viol, gap, rdq, wmq;
  } mon_t;

  int n_vin = 0, n_bias = 0, n_adder = 0, n_done = 0, n_busy = 0;
  int n_cvt = 0, n_brst = 0, n_viol = 0, n_gap = 0;
  logic [FM_AW-1:0] rd_q[$];
  logic [WM_AW-1:0] wm_q[$];

  always @(negedge clk) begin
    if (rstn) begin
      if (conv_data_valid_in) begin
        n_vin++;
        rd_q.push_back(fm_rd_addr);
        if (stall_q) n_viol++;
      end
      if (current_state == 3'd3 && !conv_data_valid_in) n_gap++;
      if (bias_out_valid) begin
        n_bias++;
        wm_q.push_back(wm_addr_rd);
      end
      if (adder_rst)    n_adder++;
      if (done)         n_done++;
      if (busy)         n_busy++;
      if (!wm_cvt_rstn) n_cvt++;
      if (buff_len_rst) n_brst++;
    end
  end

  function automatic mon_t snap();
    mon_t m;
    m.vin = n_vin;   m.bias = n_bias; m.adder = n_adder; m.dn = n_done;
    m.bsy = n_busy;  m.cvt = n_cvt;   m.brst = n_brst;   m.viol = n_viol;
    m.gap = n_gap;   m.rdq = rd_q.size(); m.wmq = wm_q.size();
    return m;
  endfunction

  function automatic logic [31:0] rd_at(input int idx);
    return (idx < rd_q.size()) ? 32'(rd_q[idx]) : 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] wm_at(input int idx);
    return (idx < wm_q.size()) ? 32'(wm_q[idx]) : 32'hDEAD_BEEF;
  endfunction

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_start(input logic [FM_AW-1:0] rd, input logic [FM_AW-1:0] wr,
                          input logic [FM_AW-1:0] pix, input logic [WM_AW-1:0] grp);
    @(negedge clk);
    cfg_fm_rd_base = rd;
    cfg_fm_wr_base = wr;
    cfg_pix_num    = pix;
    cfg_groups     = grp;
    start          = 1'b1;
    @(negedge clk);
    start          = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int max_cyc);
    bit seen = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
  endtask

  task automatic wait_state(input string tag, input logic [2:0] st, input int max_cyc);
    bit seen = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (current_state == st) begin
        seen = 1'b1;
        break;
      end
    end
    check({tag, "_state_seen"}, 32'(seen), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    mon_t m0, m1;
    logic [31:0] wrap_exp [4];

    rstn = 1'b1;
    #2 rstn = 1'b0;
    #20;
    check("rst_state", 32'(current_state), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_cvt_rstn", 32'(wm_cvt_rstn), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_rd_addr", 32'(fm_rd_addr), 32'd0);
    check("rst_bias_v", 32'(bias_out_valid), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    // 1: basic layer, two groups of four pixels, no stall
    cfg_scale = 4'd5; cfg_pw_mode = 1'b1; cfg_row_len = 9'd28;
    m0 = snap();
    do_start(13'h100, 13'h200, 13'd4, 8'd2);
    check("t1_state_wcvt", 32'(current_state), 32'd1);
    check("t1_cvt_rstn_low", 32'(wm_cvt_rstn), 32'd0);
    check("t1_buf_rst_pulse", 32'(buff_len_rst), 32'd1);
    check("t1_busy", 32'(busy), 32'd1);
    @(negedge clk);
    check("t1_cvt_rstn_rel", 32'(wm_cvt_rstn), 32'd1);
    check("t1_buf_rst_end", 32'(buff_len_rst), 32'd0);
    wait_done("t1", 300);
    @(negedge clk);
    m1 = snap();
    check("t1_vin_cnt", 32'(m1.vin - m0.vin), 32'd8);
    for (int i = 0; i < 8; i++)
      check($sformatf("t1_rd_addr%0d", i), rd_at(m0.rdq + i), 32'h100 + 32'(i % 4));
    check("t1_wr_addr_end", 32'(fm_wr_addr), 32'h208);
    check("t1_bias_cnt", 32'(m1.bias - m0.bias), 32'd2);
    check("t1_wm_addr0", wm_at(m0.wmq), 32'd0);
    check("t1_wm_addr1", wm_at(m0.wmq + 1), 32'd1);
    check("t1_bm_addr_last", 32'(bm_addr_rd), 32'd1);
    check("t1_adder_cnt", 32'(m1.adder - m0.adder), 32'd2);
    check("t1_done_cnt", 32'(m1.dn - m0.dn), 32'd1);
    check("t1_cvt_cnt", 32'(m1.cvt - m0.cvt), 32'd1);
    check("t1_brst_cnt", 32'(m1.brst - m0.brst), 32'd1);
    check("t1_busy_cycles", 32'(m1.bsy - m0.bsy), 32'd36);
    check("t1_gap", 32'(m1.gap - m0.gap), 32'd0);
    check("t1_scale", 32'(conv_scale), 32'd5);
    check("t1_pw_mode", 32'(pw_mode), 32'd1);
    check("t1_buff_len", 32'(buff_len_ctrl), 32'd28);
    check("t1_idle", 32'(current_state), 32'd0);
`ifdef CONV_SEQ_PERF_CNT_EN
    check("t6_perf_cycles", perf_cycles, 32'd36);
`endif

    // 2: stall in STREAM
    stall_arm = 1'b1;
    m0 = snap();
    do_start(13'h040, 13'h300, 13'd3, 8'd1);
`ifdef CONV_SEQ_PERF_CNT_EN
    check("t6_perf_clear", perf_cycles, 32'd0);
`endif
    wait_done("t2", 300);
    @(negedge clk);
    stall_arm = 1'b0;
    m1 = snap();
    check("t2_vin_cnt", 32'(m1.vin - m0.vin), 32'd3);
    for (int i = 0; i < 3; i++)
      check($sformatf("t2_rd_addr%0d", i), rd_at(m0.rdq + i), 32'h040 + 32'(i));
    check("t2_valid_in_stall", 32'(m1.viol - m0.viol), 32'd0);
    check("t2_stall_gap", 32'(m1.gap - m0.gap), 32'd5);
    check("t2_wr_addr_end", 32'(fm_wr_addr), 32'h303);
    check("t2_done_cnt", 32'(m1.dn - m0.dn), 32'd1);

    // 3: zero groups goes straight to DONE
    repeat (2) @(negedge clk);
    m0 = snap();
    do_start(13'h055, 13'h066, 13'd4, 8'd0);
    check("t3_state_done", 32'(current_state), 32'd5);
    check("t3_done", 32'(done), 32'd1);
    check("t3_rd_base", 32'(fm_rd_addr), 32'h055);
    check("t3_wr_base", 32'(fm_wr_addr), 32'h066);
    @(negedge clk);
    check("t3_state_idle", 32'(current_state), 32'd0);
    check("t3_done_end", 32'(done), 32'd0);
    repeat (3) @(negedge clk);
    m1 = snap();
    check("t3_vin_cnt", 32'(m1.vin - m0.vin), 32'd0);
    check("t3_bias_cnt", 32'(m1.bias - m0.bias), 32'd0);
    check("t3_cvt_cnt", 32'(m1.cvt - m0.cvt), 32'd0);
    check("t3_done_cnt", 32'(m1.dn - m0.dn), 32'd1);

    // 4: abort in DRAIN, then a clean restart
    cfg_scale = 4'd9;
    m0 = snap();
    do_start(13'h000, 13'h400, 13'd4, 8'd2);
    wait_state("t4_drain", 3'd4, 300);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("t4_state_idle", 32'(current_state), 32'd0);
    check("t4_busy", 32'(busy), 32'd0);
    check("t4_valid_in", 32'(conv_data_valid_in), 32'd0);
    check("t4_scale_kept", 32'(conv_scale), 32'd9);
    repeat (8) @(negedge clk);
    m1 = snap();
    check("t4_no_done", 32'(m1.dn - m0.dn), 32'd0);
    m0 = snap();
    do_start(13'h010, 13'h020, 13'd2, 8'd1);
    check("t4_restart_wcvt", 32'(current_state), 32'd1);
    wait_done("t4r", 300);
    @(negedge clk);
    m1 = snap();
    check("t4r_vin_cnt", 32'(m1.vin - m0.vin), 32'd2);
    check("t4r_rd_addr0", rd_at(m0.rdq), 32'h010);
    check("t4r_rd_addr1", rd_at(m0.rdq + 1), 32'h011);
    check("t4r_wr_addr_end", 32'(fm_wr_addr), 32'h022);
    check("t4r_done_cnt", 32'(m1.dn - m0.dn), 32'd1);

    // 5: address wrap with one surplus result that must be ignored
    wrap_exp[0] = 32'h1FFE; wrap_exp[1] = 32'h1FFF;
    wrap_exp[2] = 32'h0000; wrap_exp[3] = 32'h0001;
    dup_mode = 1'b1;
    m0 = snap();
    do_start(13'h1FFE, 13'h1FFF, 13'd4, 8'd1);
    wait_done("t5", 300);
    repeat (3) @(negedge clk);
    dup_mode = 1'b0;
    m1 = snap();
    check("t5_vin_cnt", 32'(m1.vin - m0.vin), 32'd4);
    for (int i = 0; i < 4; i++)
      check($sformatf("t5_rd_addr%0d", i), rd_at(m0.rdq + i), wrap_exp[i]);
    check("t5_wr_addr_wrap", 32'(fm_wr_addr), 32'h0003);
    check("t5_done_cnt", 32'(m1.dn - m0.dn), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
